// File: rtl/hls_sched_dp_pkg.sv
// Shared types, state encoding and narrowing helper for the scheduled
// (a+b)*c - a*b datapath.
package hls_sched_pkg;

  // Binary state encoding, exposed so checkers can decode the debug port.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd1;
  localparam logic [2:0] ST_S2   = 3'd2;
  localparam logic [2:0] ST_S3   = 3'd3;
  localparam logic [2:0] ST_S4   = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    S1   = ST_S1,
    S2   = ST_S2,
    S3   = ST_S3,
    S4   = ST_S4,
    FIN  = ST_FIN
  } sched_state_t;

  // Clamp a sign-extended value into the signed range of a dw-bit word.
  // Works on a 64-bit container, so callers must keep 2*dw <= 64.
  function automatic logic signed [63:0] sat_narrow(
    input logic signed [63:0] value,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (value > hi) begin
      sat_narrow = hi;
    end else if (value < lo) begin
      sat_narrow = lo;
    end else begin
      sat_narrow = value;
    end
  endfunction

endpackage

// File: rtl/hls_sched_dp_if.sv
// Request/result bundle between the control sequencer (master) and the
// scheduled datapath (slave).
//
// Handshake: the master raises start with a/b/c valid; the slave accepts
// only while busy is low (start while busy is dropped, not queued). Operands
// are don't-care outside the accept cycle. done is a one-cycle pulse marking
// the cycle in which x/z carry the new result; x/z then hold until the next
// done.
interface hls_sched_dp_if #(
  parameter int DW = 8
);
  logic                   start;
  logic signed [DW-1:0]   a;
  logic signed [DW-1:0]   b;
  logic signed [DW-1:0]   c;
  logic                   busy;
  logic                   done;
  logic signed [DW-1:0]   z;
  logic signed [2*DW-1:0] x;

  modport master (
    output start, a, b, c,
    input  busy, done, z, x
  );

  modport slave (
    input  start, a, b, c,
    output busy, done, z, x
  );
endinterface

// File: rtl/hls_sched_dp_narrow.sv
// Combinational 2*DW -> DW narrowing: saturating clamp or plain truncation.
module hls_narrow
  import hls_sched_pkg::*;
#(
  parameter int DW  = 8,
  parameter bit SAT = 1'b1
) (
  input  logic signed [2*DW-1:0] din,
  output logic signed [DW-1:0]   dout
);

  logic signed [63:0] din_ext;

  // Sign-extend into the helper's fixed container.
  always_comb begin
    din_ext = 64'(din);
  end

  // Select clamp or wrap; the clamp result always fits in DW bits.
  always_comb begin
    if (SAT) begin
      dout = DW'(sat_narrow(din_ext, DW));
    end else begin
      dout = din[DW-1:0];
    end
  end

endmodule

// File: rtl/hls_sched_dp.sv
// Resource-constrained FSMD computing x = (a+b)*c - a*b and a narrowed z,
// using one shared multiplier and one shared adder/subtractor over 4 states.
module hls_sched_dp
  import hls_sched_pkg::*;
#(
  parameter int DW  = 8,
  parameter bit SAT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  hls_sched_dp_if.slave        bus,
  output logic [2:0]           state_dbg
);

  localparam int XW = 2 * DW;

  sched_state_t state, state_nxt;

  // Control strobes decoded from the current state.
  logic ld_ops, ld_e, ld_f, ld_g, ld_xw, ld_out;
  logic mul_sel;   // 0: e*rc, 1: ra*rb
  logic op_sub;    // 0: ra+rb, 1: f-g

  // Operand and intermediate registers.
  logic signed [DW-1:0] ra, rb, rc, e;
  logic signed [XW-1:0] f, g, xw;

  // Output registers.
  logic signed [XW-1:0] x_q;
  logic signed [DW-1:0] z_q;
  logic                 done_q, busy_q;

  // Shared operator inputs/results.
  logic signed [DW-1:0] mul_a, mul_b;
  logic signed [XW-1:0] mul_ax, mul_bx, prod;
  logic signed [XW-1:0] add_a, add_b, addsub;
  logic signed [DW-1:0] z_nxt;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fixed schedule once a request is accepted in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? S1 : IDLE;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = S4;
      S4:      state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: which register loads and how the shared units are steered.
  always_comb begin
    ld_ops  = 1'b0;
    ld_e    = 1'b0;
    ld_f    = 1'b0;
    ld_g    = 1'b0;
    ld_xw   = 1'b0;
    ld_out  = 1'b0;
    mul_sel = 1'b0;
    op_sub  = 1'b0;
    case (state)
      IDLE: ld_ops = bus.start;
      S1:   ld_e   = 1'b1;
      S2:   ld_f   = 1'b1;
      S3: begin
        ld_g    = 1'b1;
        mul_sel = 1'b1;
      end
      S4: begin
        ld_xw  = 1'b1;
        op_sub = 1'b1;
      end
      FIN:  ld_out = 1'b1;
      default: ;
    endcase
  end

  // Single shared multiplier: operands sign-extended so the low XW bits of
  // the product equal the full signed DW x DW product.
  always_comb begin
    mul_a  = mul_sel ? ra : e;
    mul_b  = mul_sel ? rb : rc;
    mul_ax = {{DW{mul_a[DW-1]}}, mul_a};
    mul_bx = {{DW{mul_b[DW-1]}}, mul_b};
    prod   = mul_ax * mul_bx;
  end

  // Single shared adder/subtractor; e keeps only the low DW bits (wraps).
  always_comb begin
    add_a  = op_sub ? f : {{DW{ra[DW-1]}}, ra};
    add_b  = op_sub ? g : {{DW{rb[DW-1]}}, rb};
    addsub = op_sub ? (add_a - add_b) : (add_a + add_b);
  end

  hls_narrow #(
    .DW  (DW),
    .SAT (SAT)
  ) u_narrow (
    .din  (xw),
    .dout (z_nxt)
  );

  // Datapath and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      rc     <= '0;
      e      <= '0;
      f      <= '0;
      g      <= '0;
      xw     <= '0;
      x_q    <= '0;
      z_q    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (ld_ops) begin
        ra <= bus.a;
        rb <= bus.b;
        rc <= bus.c;
      end
      if (ld_e)  e  <= addsub[DW-1:0];
      if (ld_f)  f  <= prod;
      if (ld_g)  g  <= prod;
      if (ld_xw) xw <= addsub;
      if (ld_out) begin
        x_q <= xw;
        z_q <= z_nxt;
      end
      done_q <= ld_out;
      busy_q <= (state_nxt != IDLE);
    end
  end

  assign bus.x     = x_q;
  assign bus.z     = z_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_hls_sched_dp.sv
// Directed bench for hls_sched_dp: three instances (8-bit saturating,
// 8-bit wrapping, 16-bit saturating) driven from one linear sequence.
module tb_hls_sched_dp;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_seen;

  always #5 clk = ~clk;

  hls_sched_dp_if #(.DW(8))  bus8s ();
  hls_sched_dp_if #(.DW(8))  bus8w ();
  hls_sched_dp_if #(.DW(16)) bus16 ();

  logic [2:0] st8s, st8w, st16;

  hls_sched_dp #(.DW(8), .SAT(1'b1)) u_8s (
    .clk(clk), .rst(rst), .bus(bus8s.slave), .state_dbg(st8s)
  );
  hls_sched_dp #(.DW(8), .SAT(1'b0)) u_8w (
    .clk(clk), .rst(rst), .bus(bus8w.slave), .state_dbg(st8w)
  );
  hls_sched_dp #(.DW(16), .SAT(1'b1)) u_16 (
    .clk(clk), .rst(rst), .bus(bus16.slave), .state_dbg(st16)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset held 2 cycles with start high: nothing may start
    rst = 1'b1;
    bus8s.start = 1'b1; bus8s.a = 8'sd3;  bus8s.b = 8'sd4;  bus8s.c = 8'sd5;
    bus8w.start = 1'b1; bus8w.a = 8'sd3;  bus8w.b = 8'sd4;  bus8w.c = 8'sd5;
    bus16.start = 1'b1; bus16.a = 16'sd3; bus16.b = 16'sd4; bus16.c = 16'sd5;
    tick(); tick();
    check("rst_x_8s", bus8s.x, 0);
    check("rst_z_8s", bus8s.z, 0);
    check("rst_done_8s", bus8s.done, 0);
    check("rst_busy_8s", bus8s.busy, 0);
    check("rst_state_8s", st8s, 0);
    check("rst_x_8w", bus8w.x, 0);
    check("rst_busy_8w", bus8w.busy, 0);
    check("rst_x_16", bus16.x, 0);
    check("rst_busy_16", bus16.busy, 0);
    rst = 1'b0;
    bus8s.start = 1'b0; bus8w.start = 1'b0; bus16.start = 1'b0;
    tick();
    check("post_rst_busy_8s", bus8s.busy, 0);
    check("post_rst_state_16", st16, 0);

    // ---- basic: 3,4,5 -> (7*5) - 12 = 23
    bus8s.a = 8'sd3; bus8s.b = 8'sd4; bus8s.c = 8'sd5; bus8s.start = 1'b1;
    tick();
    bus8s.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("basic_busy_%0d", i), bus8s.busy, 1);
      check($sformatf("basic_nodone_%0d", i), bus8s.done, 0);
      tick();
    end
    check("basic_done", bus8s.done, 1);
    check("basic_busy_in_done", bus8s.busy, 0);
    check("basic_x", bus8s.x, 23);
    check("basic_z", bus8s.z, 23);
    tick();
    check("basic_done_pulse", bus8s.done, 0);
    check("basic_x_hold", bus8s.x, 23);
    check("basic_z_hold", bus8s.z, 23);

    // ---- narrowing: -128 each -> e wraps to 0, x = -16384
    bus8s.a = -8'sd128; bus8s.b = -8'sd128; bus8s.c = -8'sd128; bus8s.start = 1'b1;
    bus8w.a = -8'sd128; bus8w.b = -8'sd128; bus8w.c = -8'sd128; bus8w.start = 1'b1;
    tick();
    bus8s.start = 1'b0; bus8w.start = 1'b0;
    repeat (5) tick();
    check("narrow_done_8s", bus8s.done, 1);
    check("narrow_x_8s", bus8s.x, -16384);
    check("narrow_z_sat", bus8s.z, -128);
    check("narrow_done_8w", bus8w.done, 1);
    check("narrow_x_8w", bus8w.x, -16384);
    check("narrow_z_wrap", bus8w.z, 0);
    tick();

    // ---- start pulsed in S2 with other operands is ignored: 10,-3,7 -> 79
    bus8s.a = 8'sd10; bus8s.b = -8'sd3; bus8s.c = 8'sd7; bus8s.start = 1'b1;
    tick();
    bus8s.start = 1'b0;
    tick();
    check("ign_state_s2", st8s, 2);
    bus8s.a = 8'sd100; bus8s.b = 8'sd100; bus8s.c = 8'sd100; bus8s.start = 1'b1;
    tick();
    bus8s.start = 1'b0;
    repeat (3) tick();
    check("ign_done", bus8s.done, 1);
    check("ign_x", bus8s.x, 79);
    check("ign_z", bus8s.z, 79);
    tick();
    check("ign_not_queued_busy", bus8s.busy, 0);
    check("ign_not_queued_state", st8s, 0);

    // ---- start held high: -5,2,9 -> (-3*9) - (-10) = -17 every 6 cycles
    bus8w.a = -8'sd5; bus8w.b = 8'sd2; bus8w.c = 8'sd9; bus8w.start = 1'b1;
    tick();
    repeat (5) tick();
    check("b2b_done_1", bus8w.done, 1);
    check("b2b_busy_in_done_1", bus8w.busy, 0);
    check("b2b_x_1", bus8w.x, -17);
    check("b2b_z_1", bus8w.z, -17);
    tick();
    check("b2b_reaccept_busy", bus8w.busy, 1);
    check("b2b_gap_done", bus8w.done, 0);
    repeat (4) tick();
    check("b2b_gap_done_late", bus8w.done, 0);
    tick();
    check("b2b_done_2", bus8w.done, 1);
    check("b2b_x_2", bus8w.x, -17);
    bus8w.start = 1'b0;
    tick();
    check("b2b_stop_busy", bus8w.busy, 0);

    // ---- reset in S3 aborts; outputs clear; next op is correct
    bus8s.a = 8'sd3; bus8s.b = 8'sd4; bus8s.c = 8'sd5; bus8s.start = 1'b1;
    tick();
    bus8s.start = 1'b0;
    tick(); tick();
    check("abort_state_s3", st8s, 3);
    rst = 1'b1;
    tick();
    check("abort_state", st8s, 0);
    check("abort_x", bus8s.x, 0);
    check("abort_z", bus8s.z, 0);
    check("abort_busy", bus8s.busy, 0);
    check("abort_done", bus8s.done, 0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus8s.done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    bus8s.a = -8'sd7; bus8s.b = 8'sd6; bus8s.c = -8'sd3; bus8s.start = 1'b1;
    tick();
    bus8s.start = 1'b0;
    repeat (5) tick();
    check("after_abort_done", bus8s.done, 1);
    check("after_abort_x", bus8s.x, 45);
    check("after_abort_z", bus8s.z, 45);

    // ---- 16-bit: 300,-200,1000 -> 100000 + 60000 = 160000, z clamps
    bus16.a = 16'sd300; bus16.b = -16'sd200; bus16.c = 16'sd1000; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    repeat (5) tick();
    check("w16_done", bus16.done, 1);
    check("w16_x", bus16.x, 160000);
    check("w16_z", bus16.z, 32767);
    tick();
    check("w16_done_pulse", bus16.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
